// File: rtl/switch_core.sv
// Central 4-port crossbar: round-robin grant, one-cycle FIFO write, 4-phase ack to source.
// Optional ACK-phase timeout guarded by SWITCH_TIMEOUT_EN (adds err_o).
module switch_core #(
  parameter int DW     = 4,
  parameter int NP     = 4,
  parameter int TO_CYC = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NP-1:0]    validtx_i,
  input  logic [NP*DW-1:0] dat_i,
  input  logic [2*NP-1:0]  adr_i,
  output logic [NP-1:0]    acktx_o,
  input  logic [NP-1:0]    full_i,
  output logic [DW-1:0]    fifo_o,
  output logic [NP-1:0]    wen_o
`ifdef SWITCH_TIMEOUT_EN
  ,
  output logic             err_o
`endif
);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t      state;
  logic [1:0]  rr_ptr, src, pick;
  logic        found;
  logic [NP-1:0] elig, blk;

`ifdef SWITCH_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0] to_cnt;
`else
  assign blk = '0;
`endif

  // A request is only eligible if its target FIFO can take the word now.
  for (genvar p = 0; p < NP; p++) begin : g_elig
    assign elig[p] = validtx_i[p] & ~full_i[adr_i[p*2 +: 2]] & ~blk[p];
  end

  // Scan from rr_ptr upward; descending loop so the nearest offset wins.
  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    found = 1'b0;
    pick  = rr_ptr;
    for (int k = NP - 1; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      src     <= '0;
      acktx_o <= '0;
      wen_o   <= '0;
      fifo_o  <= '0;
`ifdef SWITCH_TIMEOUT_EN
      err_o   <= 1'b0;
      to_cnt  <= '0;
      blk     <= '0;
`endif
    end else begin
      wen_o <= '0;
`ifdef SWITCH_TIMEOUT_EN
      err_o <= 1'b0;
      // A timed-out source stays locked out until it drops its request.
      blk   <= blk & validtx_i;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            src                       <= pick;
            wen_o[adr_i[pick*2 +: 2]] <= 1'b1;
            fifo_o                    <= dat_i[pick*DW +: DW];
            state                     <= XFER;
          end
        end
        XFER: begin
          acktx_o[src] <= 1'b1;
          state        <= ACK;
`ifdef SWITCH_TIMEOUT_EN
          to_cnt       <= '0;
`endif
        end
        ACK: begin
          if (!validtx_i[src]) begin
            acktx_o <= '0;
            rr_ptr  <= src + 2'd1;
            state   <= IDLE;
          end
`ifdef SWITCH_TIMEOUT_EN
          else if (to_cnt == CW'(TO_CYC - 1)) begin
            acktx_o  <= '0;
            err_o    <= 1'b1;
            blk[src] <= 1'b1;
            rr_ptr   <= src + 2'd1;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_core.sv
// Directed bench for switch_core: latency, round-robin order, full blocking, loopback, reset abort.
module tb_switch_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  validtx, full, ack, wen;
  logic [15:0] dat;
  logic [7:0]  adr;
  logic [3:0]  fifo;
`ifdef SWITCH_TIMEOUT_EN
  logic        err;
`endif

  int tests = 0;
  int fails = 0;

  logic [3:0] wdat [8];
  logic [3:0] wdst [8];
  int nw, nack;

  switch_core #(.DW(4), .NP(4), .TO_CYC(15)) dut (
    .clk_i(clk), .rst_i(rst), .validtx_i(validtx), .dat_i(dat), .adr_i(adr),
    .acktx_o(ack), .full_i(full), .fifo_o(fifo), .wen_o(wen)
`ifdef SWITCH_TIMEOUT_EN
    , .err_o(err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [1:0] a, input logic [3:0] d);
    adr[p*2 +: 2] = a;
    dat[p*4 +: 4] = d;
    validtx[p]    = 1'b1;
  endtask

  task automatic do_reset;
    rst = 1'b1; validtx = '0; full = '0; dat = '0; adr = '0;
    step; step;
    rst = 1'b0;
  endtask

  // Acts as every source (drops request on ack) and logs FIFO writes.
  task automatic collect(input int n);
    repeat (n) begin
      step;
      if (wen != 4'b0 && nw < 8) begin
        wdst[nw] = wen; wdat[nw] = fifo; nw++;
      end
      if (ack != 4'b0) nack++;
      for (int p = 0; p < 4; p++) if (ack[p]) validtx[p] = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; validtx = '1; full = '0; dat = 16'hFFFF; adr = '0;
    step; step;
    tests++; if (ack !== 4'b0) begin fails++; $display("FAIL reset_ack got %b want 0000", ack); end
    tests++; if (wen !== 4'b0) begin fails++; $display("FAIL reset_wen got %b want 0000", wen); end
    tests++; if (fifo !== 4'h0) begin fails++; $display("FAIL reset_fifo got %h want 0", fifo); end
`ifdef SWITCH_TIMEOUT_EN
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
`endif
    validtx = '0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset;
    set_req(1, 2'd2, 4'hA);
    step;
    tests++; if (wen !== 4'b0100) begin fails++; $display("FAIL single_wen got %b want 0100", wen); end
    tests++; if (fifo !== 4'hA) begin fails++; $display("FAIL single_fifo got %h want a", fifo); end
    tests++; if (ack !== 4'b0) begin fails++; $display("FAIL single_ack_early got %b want 0000", ack); end
    dat[4 +: 4] = 4'h3;  // post-grant change must not matter
    step;
    tests++; if (wen !== 4'b0) begin fails++; $display("FAIL single_wen_once got %b want 0000", wen); end
    tests++; if (ack !== 4'b0010) begin fails++; $display("FAIL single_ack got %b want 0010", ack); end
    tests++; if (fifo !== 4'hA) begin fails++; $display("FAIL single_fifo_hold got %h want a", fifo); end
    step;
    tests++; if (ack !== 4'b0010) begin fails++; $display("FAIL single_ack_hold got %b want 0010", ack); end
    validtx[1] = 1'b0;
    step;
    tests++; if (ack !== 4'b0) begin fails++; $display("FAIL single_ack_drop got %b want 0000", ack); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_d [3];
    exp_d[0] = 4'h1; exp_d[1] = 4'h2; exp_d[2] = 4'h3;
    do_reset;
    set_req(0, 2'd2, 4'h1); set_req(1, 2'd2, 4'h2); set_req(3, 2'd2, 4'h3);
    nw = 0; nack = 0;
    collect(20);
    tests++; if (nw !== 3) begin fails++; $display("FAIL rr_count got %0d want 3", nw); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (wdat[i] !== exp_d[i]) begin fails++; $display("FAIL rr_data%0d got %h want %h", i, wdat[i], exp_d[i]); end
      tests++; if (wdst[i] !== 4'b0100) begin fails++; $display("FAIL rr_dst%0d got %b want 0100", i, wdst[i]); end
    end
  endtask

  task automatic test_full_block;
    do_reset;
    full = 4'b1000;
    set_req(0, 2'd3, 4'h6); set_req(2, 2'd1, 4'h9);
    nw = 0; nack = 0;
    collect(10);
    tests++; if (nw !== 1) begin fails++; $display("FAIL full_count1 got %0d want 1", nw); end
    tests++; if (wdst[0] !== 4'b0010) begin fails++; $display("FAIL full_dst1 got %b want 0010", wdst[0]); end
    tests++; if (wdat[0] !== 4'h9) begin fails++; $display("FAIL full_data1 got %h want 9", wdat[0]); end
    full = 4'b0;
    nw = 0;
    collect(10);
    tests++; if (nw !== 1) begin fails++; $display("FAIL full_count2 got %0d want 1", nw); end
    tests++; if (wdst[0] !== 4'b1000) begin fails++; $display("FAIL full_dst2 got %b want 1000", wdst[0]); end
    tests++; if (wdat[0] !== 4'h6) begin fails++; $display("FAIL full_data2 got %h want 6", wdat[0]); end
  endtask

  task automatic test_loopback;
    do_reset;
    set_req(3, 2'd3, 4'h5);
    step;
    tests++; if (wen !== 4'b1000) begin fails++; $display("FAIL loop_wen got %b want 1000", wen); end
    tests++; if (fifo !== 4'h5) begin fails++; $display("FAIL loop_fifo got %h want 5", fifo); end
    step;
    tests++; if (ack !== 4'b1000) begin fails++; $display("FAIL loop_ack got %b want 1000", ack); end
    validtx[3] = 1'b0;
    step;
    tests++; if (ack !== 4'b0) begin fails++; $display("FAIL loop_ack_drop got %b want 0000", ack); end
  endtask

  task automatic test_withdraw;
    do_reset;
    full = 4'b0001;
    set_req(1, 2'd0, 4'hC);
    step; step;
    validtx[1] = 1'b0;
    full = 4'b0;
    nw = 0; nack = 0;
    collect(6);
    tests++; if (nw !== 0) begin fails++; $display("FAIL withdraw_writes got %0d want 0", nw); end
    tests++; if (nack !== 0) begin fails++; $display("FAIL withdraw_acks got %0d want 0", nack); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    set_req(2, 2'd0, 4'h7);
    step;
    tests++; if (wen !== 4'b0001) begin fails++; $display("FAIL rstmid_wen got %b want 0001", wen); end
    rst = 1'b1;
    set_req(0, 2'd1, 4'h8);
    step;
    tests++; if (wen !== 4'b0) begin fails++; $display("FAIL rstmid_wen_abort got %b want 0000", wen); end
    tests++; if (ack !== 4'b0) begin fails++; $display("FAIL rstmid_ack got %b want 0000", ack); end
    rst = 1'b0;
    nw = 0; nack = 0;
    collect(20);
    tests++; if (nw !== 2) begin fails++; $display("FAIL rstmid_count got %0d want 2", nw); end
    tests++; if (wdat[0] !== 4'h8) begin fails++; $display("FAIL rstmid_first_data got %h want 8", wdat[0]); end
    tests++; if (wdst[0] !== 4'b0010) begin fails++; $display("FAIL rstmid_first_dst got %b want 0010", wdst[0]); end
    tests++; if (wdat[1] !== 4'h7) begin fails++; $display("FAIL rstmid_second_data got %h want 7", wdat[1]); end
  endtask

`ifdef SWITCH_TIMEOUT_EN
  task automatic test_timeout;
    int ack_cyc, err_cnt;
    logic [3:0] ack_at_err;
    do_reset;
    set_req(1, 2'd0, 4'h3); set_req(2, 2'd0, 4'h4);
    ack_cyc = 0; err_cnt = 0; ack_at_err = 4'hF; nw = 0;
    repeat (40) begin
      step;
      if (ack[1]) ack_cyc++;
      if (err) begin err_cnt++; ack_at_err = ack; end
      if (ack[2]) validtx[2] = 1'b0;
      if (wen != 4'b0 && nw < 8) begin wdst[nw] = wen; wdat[nw] = fifo; nw++; end
    end
    tests++; if (ack_cyc !== 15) begin fails++; $display("FAIL to_ack_cycles got %0d want 15", ack_cyc); end
    tests++; if (err_cnt !== 1) begin fails++; $display("FAIL to_err_pulses got %0d want 1", err_cnt); end
    tests++; if (ack_at_err !== 4'b0) begin fails++; $display("FAIL to_ack_at_err got %b want 0000", ack_at_err); end
    tests++; if (nw !== 2) begin fails++; $display("FAIL to_writes got %0d want 2", nw); end
    tests++; if (wdat[1] !== 4'h4) begin fails++; $display("FAIL to_next_data got %h want 4", wdat[1]); end
    validtx[1] = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; validtx = '0; full = '0; dat = '0; adr = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_full_block;
    test_loopback;
    test_withdraw;
    test_reset_mid;
`ifdef SWITCH_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
